alu_issue_ctrl: RTL and testbench

- Issue/writeback controller wrapped around the combinational ALU.
- Accepts one instruction at a time on a valid/ready handshake and reads operands from an internal 8x32 register file.
- Drives the ALU's operand1/operand2/alu_op inputs from registered values, then captures the ALU result and writes it back.
- Sits directly upstream of the ALU, feeding it, and consumes its result output.

---
 rtl/alu_issue_ctrl_if.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of instruction, ALU, writeback and debug signals between the issue
// controller, its instruction source and the combinational ALU.
interface alu_issue_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 3
);
   logic              instr_valid;
   logic              instr_ready;
   logic [2:0]        instr_op;
   logic [REG_AW-1:0] instr_rd;
   logic [REG_AW-1:0] instr_rs1;
   logic [REG_AW-1:0] instr_rs2;
   logic              instr_imm_en;
   logic [DATA_W-1:0] instr_imm;
   logic [DATA_W-1:0] alu_operand1;
   logic [DATA_W-1:0] alu_operand2;
   logic [2:0]        alu_op;
   logic [DATA_W-1:0] alu_result;
   logic              wb_valid;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic [REG_AW-1:0] dbg_raddr;
   logic [DATA_W-1:0] dbg_rdata;

   // Instruction source and debug reader.
   modport master (
      output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
             instr_imm_en, instr_imm, dbg_raddr,
      input  instr_ready, wb_valid, wb_rd, wb_data, dbg_rdata
   );

   // The ALU itself.
   modport alu (
      input  alu_operand1, alu_operand2, alu_op,
      output alu_result
   );

   // The issue controller.
   modport slave (
      input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
             instr_imm_en, instr_imm, alu_result, dbg_raddr,
      output instr_ready, alu_operand1, alu_operand2, alu_op,
             wb_valid, wb_rd, wb_data, dbg_rdata
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Three-cycle issue/writeback controller feeding a combinational ALU from an
// 8x32 register file whose r0 is hard-wired to zero.
module alu_issue_ctrl #(
   parameter int DATA_W = 32,
   parameter int NREG   = 8,
   parameter int REG_AW = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_issue_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] op1_q, op1_d;
   logic [DATA_W-1:0] op2_q, op2_d;
   logic [2:0]        alu_op_q, alu_op_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              wb_valid_q, wb_valid_d;
   logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic [DATA_W-1:0] rf_rd [NREG];
   logic              commit;
   logic              rf_wr_en;

   // Opcodes 000 and 001 are NOPs: nothing commits, not even the wb pulse.
   assign commit   = (state_q == S_WB) && (alu_op_q[2:1] != 2'b00);
   assign rf_wr_en = commit && (rd_q != '0);

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_rf
         if (gi == 0) begin : g_zero
            assign rf_rd[gi] = '0;
         end else begin : g_entry
            logic [DATA_W-1:0] ent_q, ent_d;
            assign ent_d = (rf_wr_en && (rd_q == REG_AW'(gi))) ? result_q : ent_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) ent_q <= '0;
               else        ent_q <= ent_d;
            end
            assign rf_rd[gi] = ent_q;
         end
      end
   endgenerate

   assign bus.instr_ready  = (state_q == S_IDLE);
   assign bus.alu_operand1 = op1_q;
   assign bus.alu_operand2 = op2_q;
   assign bus.alu_op       = alu_op_q;
   assign bus.wb_valid     = wb_valid_q;
   assign bus.wb_rd        = wb_rd_q;
   assign bus.wb_data      = wb_data_q;
   assign bus.dbg_rdata    = rf_rd[bus.dbg_raddr];

   always_comb begin
      state_d    = state_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      alu_op_d   = alu_op_q;
      rd_d       = rd_q;
      result_d   = result_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.instr_valid) begin
               op1_d    = rf_rd[bus.instr_rs1];
               op2_d    = bus.instr_imm_en ? bus.instr_imm : rf_rd[bus.instr_rs2];
               alu_op_d = bus.instr_op;
               rd_d     = bus.instr_rd;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = bus.alu_result;
            state_d  = S_WB;
         end
         S_WB: begin
            // rd==0 still pulses wb_valid; only the regfile write is dropped.
            if (commit) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = result_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op1_q      <= '0;
         op2_q      <= '0;
         alu_op_q   <= '0;
         rd_q       <= '0;
         result_q   <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         alu_op_q   <= alu_op_d;
         rd_q       <= rd_d;
         result_q   <= result_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: stub ALU, array-based register model, directed
// steps from the test plan followed by random instructions.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] ref_rf [8];

   always #5 clk = ~clk;

   alu_issue_ctrl_if #(.DATA_W(32), .REG_AW(3)) bus_if ();

   alu_issue_ctrl #(.DATA_W(32), .NREG(8), .REG_AW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // ALU behaviour the controller is wrapped around; NOP opcodes produce a
   // non-zero value so a wrongly committed NOP is visible.
   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         3'b010:  return a + b;
         3'b011:  return a - b;
         3'b100:  return (b >= 32) ? 32'd0 : (a << b[4:0]);
         3'b101:  return (b >= 32) ? 32'd0 : (a >> b[4:0]);
         3'b110:  return a | b;
         3'b111:  return a & b;
         default: return a ^ b ^ 32'hA5A5_0001;
      endcase
   endfunction

   assign bus_if.alu_result = alu_fn(bus_if.alu_op, bus_if.alu_operand1, bus_if.alu_operand2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic dbg_chk(input string tag, input int r);
      bus_if.dbg_raddr = 3'(r);
      #1;
      chk(tag, bus_if.dbg_rdata, ref_rf[r]);
   endtask

   // Entered 1ns after a rising edge with the controller idle; returns
   // 1ns after the edge that ends the wb_valid cycle.
   task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic imm_en, input logic [31:0] imm,
                            output logic [31:0] res);
      logic [31:0] a, b;
      logic        writes;
      a = ref_rf[rs1];
      b = imm_en ? imm : ref_rf[rs2];
      res = alu_fn(op, a, b);
      writes = (op > 3'd1);
      chk("ready_idle", bus_if.instr_ready, 1'b1);
      bus_if.instr_valid = 1'b1;  bus_if.instr_op = op;   bus_if.instr_rd = rd;
      bus_if.instr_rs1 = rs1;     bus_if.instr_rs2 = rs2;
      bus_if.instr_imm_en = imm_en; bus_if.instr_imm = imm;
      @(posedge clk); #1;
      bus_if.instr_valid = 1'b0;
      bus_if.instr_op = $urandom; bus_if.instr_imm = $urandom; bus_if.instr_rs1 = $urandom;
      chk("exec_op1", bus_if.alu_operand1, a);
      chk("exec_op2", bus_if.alu_operand2, b);
      chk("exec_aluop", {29'd0, bus_if.alu_op}, {29'd0, op});
      chk("exec_ready", bus_if.instr_ready, 1'b0);
      @(posedge clk); #1;
      chk("wb_state_ready", bus_if.instr_ready, 1'b0);
      chk("wb_early", bus_if.wb_valid, 1'b0);
      @(posedge clk); #1;
      chk("wb_valid", bus_if.wb_valid, writes);
      if (writes) begin
         chk("wb_rd", {29'd0, bus_if.wb_rd}, {29'd0, rd});
         chk("wb_data", bus_if.wb_data, res);
         if (rd != 0) ref_rf[rd] = res;
      end
      chk("ready_after", bus_if.instr_ready, 1'b1);
      dbg_chk("dbg_rd", int'(rd));
      @(posedge clk); #1;
      chk("wb_pulse_end", bus_if.wb_valid, 1'b0);
   endtask

   initial begin
      logic [31:0] r;
      int acc_cnt, last_acc, cyc;
      bit  prev_wb;
      rst_n = 1'b0;
      bus_if.instr_valid = 1'b0; bus_if.instr_op = '0; bus_if.instr_rd = '0;
      bus_if.instr_rs1 = '0; bus_if.instr_rs2 = '0; bus_if.instr_imm_en = 1'b0;
      bus_if.instr_imm = '0; bus_if.dbg_raddr = '0;
      for (int i = 0; i < 8; i++) ref_rf[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_valid", bus_if.wb_valid, 1'b0);
      chk("rst_op1", bus_if.alu_operand1, 32'd0);
      chk("rst_aluop", {29'd0, bus_if.alu_op}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", bus_if.instr_ready, 1'b1);
      for (int i = 0; i < 8; i++) dbg_chk("rst_rf", i);

      run_instr(3'b110, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, r);
      run_instr(3'b110, 3'd2, 3'd0, 3'd0, 1'b1, 32'd3, r);
      run_instr(3'b010, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, r);
      chk("add_r3", r, 32'd8);
      run_instr(3'b011, 3'd4, 3'd2, 3'd1, 1'b0, 32'd0, r);
      chk("sub_r4", r, 32'hFFFF_FFFE);
      run_instr(3'b100, 3'd5, 3'd3, 3'd0, 1'b1, 32'd4, r);
      chk("shl_r5", r, 32'h80);
      run_instr(3'b101, 3'd7, 3'd5, 3'd0, 1'b1, 32'd33, r);
      chk("shr33_r7", r, 32'd0);
      run_instr(3'b000, 3'd6, 3'd3, 3'd0, 1'b1, 32'hFF, r);
      dbg_chk("nop_r6", 6);
      chk("nop_r6_zero", ref_rf[6], 32'd0);
      run_instr(3'b010, 3'd0, 3'd0, 3'd0, 1'b1, 32'd7, r);
      chk("r0_wbdata", r, 32'd7);
      dbg_chk("r0_reads0", 0);

      // Back-to-back dependent increments with instr_valid held high.
      bus_if.instr_valid = 1'b1; bus_if.instr_op = 3'b010; bus_if.instr_rd = 3'd1;
      bus_if.instr_rs1 = 3'd1; bus_if.instr_imm_en = 1'b1; bus_if.instr_imm = 32'd1;
      acc_cnt = 0; last_acc = -1; prev_wb = 1'b0;
      for (cyc = 0; cyc < 30 && acc_cnt < 4; cyc++) begin
         if (bus_if.instr_ready === 1'b1) begin
            if (last_acc >= 0) chk("accept_spacing", 32'(cyc - last_acc), 32'd3);
            last_acc = cyc;
            acc_cnt++;
         end
         if (prev_wb) chk("wb_single_pulse", bus_if.wb_valid, 1'b0);
         prev_wb = bus_if.wb_valid;
         @(posedge clk); #1;
      end
      bus_if.instr_valid = 1'b0;
      chk("accept_count", 32'(acc_cnt), 32'd4);
      repeat (3) @(posedge clk);
      #1;
      ref_rf[1] = 32'd5 + 32'd4;
      dbg_chk("inc_r1", 1);

      for (int n = 0; n < 24; n++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         run_instr(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   (op == 3'b100 || op == 3'b101) ? 32'($urandom_range(0, 40)) : $urandom, r);
      end

      // Reset in the middle of EXEC must abort the write.
      bus_if.instr_valid = 1'b1; bus_if.instr_op = 3'b110; bus_if.instr_rd = 3'd7;
      bus_if.instr_rs1 = 3'd0; bus_if.instr_imm_en = 1'b1; bus_if.instr_imm = 32'h1234;
      @(posedge clk); #1;
      bus_if.instr_valid = 1'b0;
      chk("pre_abort_exec", bus_if.instr_ready, 1'b0);
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) ref_rf[i] = '0;
      #1;
      chk("abort_wb_valid", bus_if.wb_valid, 1'b0);
      chk("abort_op2", bus_if.alu_operand2, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready", bus_if.instr_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("abort_no_wb", bus_if.wb_valid, 1'b0);
         @(posedge clk); #1;
      end
      dbg_chk("abort_r7", 7);
      dbg_chk("abort_r1", 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
